// File: rtl/p_status_reg.sv
// Processor status (P) register: captures N/Z/C/V from ALU results, holds I/D,
// and provides the stackable P image plus an instruction-delayed IRQ mask.
module p_status_reg #(
    parameter bit         CMOS    = 1'b1,
    parameter logic [7:0] P_RESET = 8'h04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic [7:0] data_in,
    input  logic       load_nz,
    input  logic       load_c,
    input  logic       load_v,
    input  logic       bit_op,
    input  logic       load_p,
    input  logic       flag_wr,
    input  logic [2:0] flag_idx,
    input  logic       flag_val,
    input  logic       int_entry,
    input  logic       instr_done,
    input  logic       brk_push,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       c_out,
    output logic       d_out,
    output logic       irq_mask
);

    localparam logic [2:0] IDX_C = 3'd0;
    localparam logic [2:0] IDX_Z = 3'd1;
    localparam logic [2:0] IDX_I = 3'd2;
    localparam logic [2:0] IDX_D = 3'd3;
    localparam logic [2:0] IDX_V = 3'd6;
    localparam logic [2:0] IDX_N = 3'd7;

    logic n_q, v_q, d_q, i_q, z_q, c_q, mask_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d, mask_d;
    logic alu_zero_s;

    function automatic logic is_zero(input logic [7:0] val);
        is_zero = (val == 8'h00);
    endfunction

    assign alu_zero_s = is_zero(alu_out);

    // Per-flag next state; each flag picks its own highest-priority source.
    always_comb begin
        n_d    = n_q;
        v_d    = v_q;
        d_d    = d_q;
        i_d    = i_q;
        z_d    = z_q;
        c_d    = c_q;
        mask_d = mask_q;

        if (load_p) begin
            n_d = data_in[7];
        end else if (flag_wr && (flag_idx == IDX_N)) begin
            n_d = flag_val;
        end else if (bit_op) begin
            n_d = data_in[7];
        end else if (load_nz) begin
            n_d = alu_out[7];
        end else begin
            n_d = n_q;
        end

        if (load_p) begin
            v_d = data_in[6];
        end else if (flag_wr && (flag_idx == IDX_V)) begin
            v_d = flag_val;
        end else if (bit_op) begin
            v_d = data_in[6];
        end else if (load_v) begin
            v_d = alu_v;
        end else begin
            v_d = v_q;
        end

        // Only 65C02 rules make interrupt entry claim D; NMOS falls through.
        if (load_p) begin
            d_d = data_in[3];
        end else if (int_entry && CMOS) begin
            d_d = 1'b0;
        end else if (flag_wr && (flag_idx == IDX_D)) begin
            d_d = flag_val;
        end else begin
            d_d = d_q;
        end

        if (load_p) begin
            i_d = data_in[2];
        end else if (int_entry) begin
            i_d = 1'b1;
        end else if (flag_wr && (flag_idx == IDX_I)) begin
            i_d = flag_val;
        end else begin
            i_d = i_q;
        end

        if (load_p) begin
            z_d = data_in[1];
        end else if (flag_wr && (flag_idx == IDX_Z)) begin
            z_d = flag_val;
        end else if (bit_op || load_nz) begin
            z_d = alu_zero_s;
        end else begin
            z_d = z_q;
        end

        if (load_p) begin
            c_d = data_in[0];
        end else if (flag_wr && (flag_idx == IDX_C)) begin
            c_d = flag_val;
        end else if (load_c) begin
            c_d = alu_c;
        end else begin
            c_d = c_q;
        end

        // Mask follows the I value landing at the instruction boundary.
        if (int_entry) begin
            mask_d = 1'b1;
        end else if (instr_done) begin
            mask_d = i_d;
        end else begin
            mask_d = mask_q;
        end
    end

    // Flag and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q    <= P_RESET[7];
            v_q    <= P_RESET[6];
            d_q    <= CMOS ? 1'b0 : P_RESET[3];
            i_q    <= P_RESET[2];
            z_q    <= P_RESET[1];
            c_q    <= P_RESET[0];
            mask_q <= 1'b1;
        end else begin
            n_q    <= n_d;
            v_q    <= v_d;
            d_q    <= d_d;
            i_q    <= i_d;
            z_q    <= z_d;
            c_q    <= c_d;
            mask_q <= mask_d;
        end
    end

    assign p_out    = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign p_push   = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
    assign c_out    = c_q;
    assign d_out    = d_q;
    assign irq_mask = mask_q;

endmodule
